alu_result_stage: RTL
=====================

# alu_result_stage

Registered, parametrised result-select stage for the ALU datapath. It picks one of NSEL operation results per transaction and zero-extends it to OUT_W. The result is buffered in a 2-entry output queue with valid/ready handshakes, and status flags and a completed-result counter are attached. It sits between the ALU operation units and the downstream consumer (display/register-file writeback), replacing the combinational 8-way result selector.

## Interface
- W, default 4: ALU operand width.
- NSEL, default 8: number of result sources; legal range 2..16.
- OUT_W, default 2*W+1 (9): result width. Every source is presented at OUT_W bits; unused upper bits are zero-extended by the ALU units.
- SEL_W, default 3: select width; must satisfy 2**SEL_W >= NSEL.
- CNT_W, default 8: result-counter width.
- clk  in  1: single clock, rising edge.
- rst_n  in  1: asynchronous, active-low reset.
- in_valid  in  1: source bus and sel are valid this cycle.
- in_ready  out  1: stage can accept a transaction.
- sel  in  SEL_W: source index.
- src  in  NSEL*OUT_W: flattened sources; source k occupies bits [k*OUT_W +: OUT_W].
- out_valid  out  1: head entry valid.
- out_ready  in  1: consumer accepts the head entry.
- out_data  out  OUT_W: head result.
- out_zero  out  1: head result == 0.
- out_neg  out  1: bit W-1 of head result set (sign of a W-bit result).
- out_err  out  1: head entry came from an illegal sel (sel >= NSEL).
- res_cnt  out  CNT_W: number of completed output handshakes, wraps modulo 2**CNT_W.

## Operation
- Input accept occurs when in_valid && in_ready. An entry {data, zero, neg, err} is captured into the queue tail.
- data = src slice[sel] if sel < NSEL; otherwise data = 0 and err = 1. zero is computed on the stored data, so an illegal sel gives zero=1, err=1.
- Output pop occurs when out_valid && out_ready. The head is removed and res_cnt increments.
- Queue depth is 2, with a count of 0/1/2 and an in-order head/tail.
- in_ready = (count != 2). It is registered-derived only, with no combinational path from out_ready.
- out_valid = (count != 0). out_data/flags come from the head register and hold stable while out_valid && !out_ready.
- Simultaneous push and pop at count 1: the count stays 1, the new entry becomes head next cycle, and the order is preserved.
- Simultaneous push and pop at count 0: only the push takes effect (nothing to pop).
- At count 2 the push is blocked, so a pop alone moves the count to 1.
- Inputs with in_valid low are ignored regardless of sel/src.
- res_cnt wraps from 2**CNT_W-1 to 0 with no saturation.

## Timing
- Latency is 1 cycle: accept at edge N gives out_valid high after edge N when the queue was empty.
- Throughput is 1 transaction/cycle while the consumer holds out_ready high.
- Reset values: out_valid=0, out_data=0, out_zero=0, out_neg=0, out_err=0, res_cnt=0, in_ready=1, count=0.
- Reset asserted mid-operation flushes both entries immediately (asynchronously). Buffered results are lost and are not counted.
- Deassertion of reset is synchronised externally; the first accept is possible on the first edge after rst_n rises.

## Structure
- Shared package/header alu_defs: ALU op select encodings (ADD=0, SUB=1, AND=2, OR=3, XOR=4, NOT=5, SHL=6, MUL=7), default W/OUT_W, and the flag bit ordering.
- One sub-module, result_fifo2: a 2-entry, width-parametrised FIFO with valid/ready on both sides. It carries {err, neg, zero, data}.
- The top level holds the select/extension logic, flag generation and res_cnt.

## Test plan
- Single pass (W=4, NSEL=8): sel=3, src[3]=9'h00A, out_ready=1 -> one cycle later out_valid=1, out_data=9'h00A, zero=0, neg=1, err=0; res_cnt=1 after pop.
- Backpressure: out_ready=0, three back-to-back valid inputs (sources 1,2,3) -> in_ready falls after 2 accepts and the third is held. Raising out_ready then yields outputs in order 1,2,3 with no loss or duplication.
- Push+pop at count 1: steady stream of 10 results with out_ready=1 -> out_valid stays high continuously and res_cnt=10.
- Illegal select (NSEL=6, SEL_W=3): sel=7, any src -> out_data=0, zero=1, err=1.
- Zero/flag case: sel=7 (MUL), src[7]=0 -> zero=1, neg=0. Then src[7]=9'h0E1 -> zero=0, neg=0, out_data=9'h0E1.
- Reset mid-operation: queue holding 2 entries, assert rst_n=0 between edges -> out_valid=0, in_ready=1, res_cnt=0 immediately. After release the next accepted result appears alone. Also a CNT_W=2 wrap check: 5 pops -> res_cnt=1.

Source files
------------

// File: rtl/alu_result_stage_pkg.sv
// Shared ALU definitions: op-select encodings, default widths and the
// bit ordering of the status flags stored alongside each result.
package alu_result_stage_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_NOT = 3'd5,
    OP_SHL = 3'd6,
    OP_MUL = 3'd7
  } alu_op_e;

  localparam int DEF_W     = 4;
  localparam int DEF_OUT_W = 2 * DEF_W + 1;
  localparam int DEF_NSEL  = 8;
  localparam int DEF_SEL_W = 3;
  localparam int DEF_CNT_W = 8;

  // Flags sit directly above the data field: entry = {err, neg, zero, data}.
  localparam int FLAG_ZERO = 0;
  localparam int FLAG_NEG  = 1;
  localparam int FLAG_ERR  = 2;
  localparam int NFLAGS    = 3;

endpackage

// File: rtl/alu_result_stage_if.sv
// Source-side and result-side handshake bundle of the ALU result stage.
// A transfer happens on a rising edge where valid && ready are both high.
interface alu_result_stage_if
  import alu_result_stage_pkg::*;
#(
  parameter int NSEL  = DEF_NSEL,
  parameter int OUT_W = DEF_OUT_W,
  parameter int SEL_W = DEF_SEL_W
) ();

  logic                    in_valid;
  logic                    in_ready;
  logic [SEL_W-1:0]        sel;
  logic [NSEL*OUT_W-1:0]   src;
  logic                    out_valid;
  logic                    out_ready;
  logic [OUT_W-1:0]        out_data;
  logic                    out_zero;
  logic                    out_neg;
  logic                    out_err;

  modport master (
    output in_valid, sel, src, out_ready,
    input  in_ready, out_valid, out_data, out_zero, out_neg, out_err
  );

  modport slave (
    input  in_valid, sel, src, out_ready,
    output in_ready, out_valid, out_data, out_zero, out_neg, out_err
  );

endinterface

// File: rtl/alu_result_stage_result_fifo2.sv
// Two-entry in-order FIFO with valid/ready on both sides. in_ready depends
// only on registered occupancy, so there is no path from out_ready to in_ready.
module result_fifo2 #(
  parameter int DW = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
);

  logic [DW-1:0] mem [2];
  logic          wr_ptr;
  logic          rd_ptr;
  logic [1:0]    count;
  logic          push;
  logic          pop;

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign out_data  = mem[rd_ptr];
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      // Push and pop together leave occupancy unchanged.
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_result_stage.sv
// Registered result-select stage: picks one of NSEL ALU results, tags it with
// zero/neg/err flags, buffers it two deep and counts completed results.
module alu_result_stage
  import alu_result_stage_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int NSEL  = DEF_NSEL,
  parameter int OUT_W = 2 * W + 1,
  parameter int SEL_W = DEF_SEL_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_result_stage_if.slave bus,
  output logic [CNT_W-1:0] res_cnt
);

  localparam int EW = OUT_W + NFLAGS;

  logic [OUT_W-1:0] sel_data;
  logic             sel_err;
  logic [EW-1:0]    in_entry;
  logic [EW-1:0]    out_entry;

  // An out-of-range select yields zero data and raises err.
  always_comb begin
    sel_data = '0;
    sel_err  = 1'b1;
    for (int k = 0; k < NSEL; k++) begin
      if (bus.sel == SEL_W'(k)) begin
        sel_data = bus.src[k*OUT_W +: OUT_W];
        sel_err  = 1'b0;
      end
    end
  end

  always_comb begin
    in_entry                   = '0;
    in_entry[OUT_W-1:0]        = sel_data;
    in_entry[OUT_W+FLAG_ZERO]  = (sel_data == '0);
    in_entry[OUT_W+FLAG_NEG]   = sel_data[W-1];
    in_entry[OUT_W+FLAG_ERR]   = sel_err;
  end

  result_fifo2 #(
    .DW (EW)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_data   (in_entry),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .out_data  (out_entry)
  );

  assign bus.out_data = out_entry[OUT_W-1:0];
  assign bus.out_zero = out_entry[OUT_W+FLAG_ZERO];
  assign bus.out_neg  = out_entry[OUT_W+FLAG_NEG];
  assign bus.out_err  = out_entry[OUT_W+FLAG_ERR];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_cnt <= '0;
    end else if (bus.out_valid && bus.out_ready) begin
      res_cnt <= res_cnt + CNT_W'(1);
    end
  end

endmodule
